// File: rtl/pixel_scaler_aligner.sv
// pixel_scaler_aligner: replicates input pixels 1x/2x/4x and packs them into x-aligned line-buffer words with per-slot write enables
module pixel_scaler_aligner #(
  parameter int PIX_W  = 9,
  parameter int IN_PIX = 4,
  parameter int LB_PIX = 8,
  parameter int X_W    = 12
) (
  input  logic                              clk_draw,
  input  logic                              rst_draw_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [IN_PIX*PIX_W-1:0]           in_pixels,
  input  logic [IN_PIX-1:0]                 in_mask,
  input  logic                              in_first,
  input  logic                              in_last,
  input  logic [X_W-1:0]                    in_x,
  input  logic [1:0]                        scale,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [X_W-$clog2(LB_PIX)-1:0]     out_addr,
  output logic [LB_PIX*PIX_W-1:0]           out_pixels,
  output logic [LB_PIX-1:0]                 out_mask
);
  localparam int LB_B = $clog2(LB_PIX);
  localparam int A_W  = X_W - LB_B;
  localparam int SL   = 3 * LB_PIX;
  localparam int FW   = $clog2(SL + 1);
  localparam logic [1:0] ACCEPT = 2'd0;
  localparam logic [1:0] EMIT   = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;

  logic [1:0]                state_q, state_d;
  logic [SL-1:0][PIX_W-1:0]  pix_q, pix_d;
  logic [SL-1:0]             msk_q, msk_d;
  logic [FW-1:0]             fill_q, fill_d;
  logic [1:0]                sh_q, sh_d;
  logic [A_W-1:0]            addr_q, addr_d;
  logic                      last_q, last_d;
  logic                      valid_q, valid_d;
  logic                      ready_q, ready_d;
  logic [FW-1:0]             base;
  logic [1:0]                sh;
  logic                      carry;

  // fill_q is the next free slot, counted from the base of the lowest word in the window
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    msk_d   = msk_q;
    fill_d  = fill_q;
    sh_d    = sh_q;
    addr_d  = addr_q;
    last_d  = last_q;
    carry   = 1'b0;
    sh      = in_first ? (scale[1] ? 2'd2 : scale) : sh_q;
    base    = in_first ? FW'(in_x[LB_B-1:0]) : fill_q;
    if (state_q == ACCEPT && in_valid && ready_q) begin
      if (in_first) begin
        pix_d  = '0;
        msk_d  = '0;
        addr_d = in_x[X_W-1:LB_B];
        sh_d   = sh;
      end
      for (int k = 0; k < 4*IN_PIX; k++)
        if (k < (IN_PIX << sh)) begin
          pix_d[base + FW'(k)] = in_pixels[(k >> sh)*PIX_W +: PIX_W];
          msk_d[base + FW'(k)] = in_mask[k >> sh];
        end
      fill_d  = base + FW'(IN_PIX << sh);
      last_d  = in_last;
      carry   = |msk_d;
      state_d = fill_d >= FW'(LB_PIX) ? EMIT : (in_last && carry) ? FLUSH : ACCEPT;
      if (fill_d < FW'(LB_PIX) && in_last && !carry) begin
        pix_d = '0;
        msk_d = '0;
      end
    end else if (state_q == EMIT && out_ready) begin
      pix_d   = pix_q >> (LB_PIX*PIX_W);
      msk_d   = msk_q >> LB_PIX;
      fill_d  = fill_q - FW'(LB_PIX);
      addr_d  = addr_q + A_W'(1);
      carry   = |msk_d;
      state_d = fill_d >= FW'(LB_PIX) ? EMIT : (last_q && carry) ? FLUSH : ACCEPT;
      if (fill_d < FW'(LB_PIX) && last_q && !carry) begin
        pix_d = '0;
        msk_d = '0;
      end
    end else if (state_q == FLUSH && out_ready) begin
      pix_d   = '0;
      msk_d   = '0;
      fill_d  = '0;
      addr_d  = addr_q + A_W'(1);
      last_d  = 1'b0;
      state_d = ACCEPT;
    end
    valid_d = state_d != ACCEPT;
    ready_d = state_d == ACCEPT;
  end

  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n) begin
      state_q <= ACCEPT;
      pix_q   <= '0;
      msk_q   <= '0;
      fill_q  <= '0;
      sh_q    <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      msk_q   <= msk_d;
      fill_q  <= fill_d;
      sh_q    <= sh_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready   = ready_q;
  assign out_valid  = valid_q;
  assign out_addr   = addr_q;
  assign out_pixels = pix_q[LB_PIX-1:0];
  assign out_mask   = msk_q[LB_PIX-1:0];
endmodule

// File: tb/tb_pixel_scaler_aligner.sv
// tb_pixel_scaler_aligner: directed table plus randomized spans checked against an absolute-x reference model
module tb_pixel_scaler_aligner;
  logic        clk_draw = 1'b0;
  logic        rst_draw_n = 1'b0;
  logic        in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [35:0] in_pixels = '0;
  logic [3:0]  in_mask = '0;
  logic [11:0] in_x = '0;
  logic [1:0]  scale = '0;
  logic [8:0]  out_addr;
  logic [71:0] out_pixels;
  logic [7:0]  out_mask;

  typedef struct packed {
    logic [8:0]  addr;
    logic [7:0]  msk;
    logic [71:0] pix;
  } exp_t;

  typedef struct {
    logic [11:0]       x;
    logic [1:0]        sc;
    int                nb;
    logic [1:0][35:0]  pix;
    logic [1:0][3:0]   msk;
    int                ne;
    exp_t [2:0]        ew;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        tv[5];
  int          n_vec = 0, n_miss = 0;
  bit          stall = 1'b0, rand_mode = 1'b0;
  logic [35:0] rp[4];
  logic [3:0]  rm[4];

  pixel_scaler_aligner dut (
    .clk_draw(clk_draw), .rst_draw_n(rst_draw_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixels(in_pixels), .in_mask(in_mask), .in_first(in_first), .in_last(in_last),
    .in_x(in_x), .scale(scale), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_pixels(out_pixels), .out_mask(out_mask)
  );

  always #5 clk_draw = ~clk_draw;

  always begin
    @(posedge clk_draw);
    #1;
    out_ready = stall ? 1'b0 : rand_mode ? ($urandom_range(3) != 0) : 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  function automatic logic [35:0] p4(input int a, b, c, d);
    return {9'(d), 9'(c), 9'(b), 9'(a)};
  endfunction

  function automatic logic [71:0] p8(input int a, b, c, d, e, f, g, h);
    return {9'(h), 9'(g), 9'(f), 9'(e), 9'(d), 9'(c), 9'(b), 9'(a)};
  endfunction

  function automatic exp_t mk(input logic [8:0] a, input logic [7:0] m, input logic [71:0] p);
    return {a, m, p};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    end
  endtask

  // Every expanded pixel has an absolute x; words are the aligned 8-pixel groups covering the span
  function automatic void model_span(input logic [11:0] x0, input logic [1:0] sc, input int nb);
    int s, len, off, tot, nw, pos, b, k;
    exp_t e;
    s   = (sc == 2'd0) ? 1 : (sc == 2'd1) ? 2 : 4;
    len = nb * 4 * s;
    off = int'(x0) % 8;
    tot = off + len;
    nw  = tot / 8;
    for (int w = 0; w <= nw; w++) begin
      e.addr = 9'((int'(x0) / 8 + w) % 512);
      e.msk  = '0;
      e.pix  = '0;
      for (int j = 0; j < 8; j++) begin
        pos = w * 8 + j - off;
        if (pos >= 0 && pos < len) begin
          b = pos / (4 * s);
          k = (pos % (4 * s)) / s;
          e.pix[j*9 +: 9] = rp[b][k*9 +: 9];
          e.msk[j]        = rm[b][k];
        end
      end
      if (w < nw || (tot % 8 != 0 && e.msk != 0)) exp_q.push_back(e);
    end
  endfunction

  always @(negedge clk_draw) begin
    if (rst_draw_n && out_valid === 1'b1 && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected word: got addr 0x%0h mask 0x%0h, expected no word", out_addr, out_mask);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("word addr", 128'(out_addr), 128'(e.addr));
        chk("word mask", 128'(out_mask), 128'(e.msk));
        chk("word pixels", 128'(out_pixels), 128'(e.pix));
      end
    end
  end

  task automatic send(input logic [35:0] p, input logic [3:0] m, input bit f, input bit l,
                      input logic [11:0] x, input logic [1:0] sc);
    int t = 0;
    in_pixels = p; in_mask = m; in_first = f; in_last = l; in_x = x; scale = sc; in_valid = 1'b1;
    while (in_ready !== 1'b1 && t < 500) begin
      @(negedge clk_draw);
      t++;
    end
    if (in_ready !== 1'b1) begin
      n_vec++;
      n_miss++;
      $display("FAIL in_ready timeout: got %b, expected 1", in_ready);
    end else begin
      @(posedge clk_draw);
      #1;
    end
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    for (int i = 0; i < v.ne; i++) exp_q.push_back(v.ew[i]);
    for (int b = 0; b < v.nb; b++) send(v.pix[b], v.msk[b], b == 0, b == v.nb - 1, v.x, v.sc);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(posedge clk_draw);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain timeout: got %0d words pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk_draw);
    #1;
  endtask

  initial begin
    logic [11:0] x;
    logic [1:0]  sc;
    int          nb;
    tv[0].x = 12'h008; tv[0].sc = 2'd1; tv[0].nb = 1; tv[0].pix[0] = p4(1,2,3,4); tv[0].msk[0] = 4'hF;
    tv[0].ne = 1; tv[0].ew[0] = mk(9'h001, 8'hFF, p8(1,1,2,2,3,3,4,4));
    tv[1].x = 12'h052; tv[1].sc = 2'd1; tv[1].nb = 1; tv[1].pix[0] = p4(5,6,7,8); tv[1].msk[0] = 4'hF;
    tv[1].ne = 2; tv[1].ew[0] = mk(9'h00A, 8'hFC, p8(0,0,5,5,6,6,7,7));
    tv[1].ew[1] = mk(9'h00B, 8'h03, p8(8,8,0,0,0,0,0,0));
    tv[2].x = 12'h003; tv[2].sc = 2'd2; tv[2].nb = 1; tv[2].pix[0] = p4(1,2,3,4); tv[2].msk[0] = 4'hF;
    tv[2].ne = 3; tv[2].ew[0] = mk(9'h000, 8'hF8, p8(0,0,0,1,1,1,1,2));
    tv[2].ew[1] = mk(9'h001, 8'hFF, p8(2,2,2,3,3,3,3,4));
    tv[2].ew[2] = mk(9'h002, 8'h07, p8(4,4,4,0,0,0,0,0));
    tv[3].x = 12'h000; tv[3].sc = 2'd0; tv[3].nb = 2; tv[3].pix[0] = p4(1,2,3,4); tv[3].msk[0] = 4'hA;
    tv[3].pix[1] = p4(5,6,7,8); tv[3].msk[1] = 4'hA;
    tv[3].ne = 1; tv[3].ew[0] = mk(9'h000, 8'hAA, p8(1,2,3,4,5,6,7,8));
    tv[4].x = 12'hFFC; tv[4].sc = 2'd1; tv[4].nb = 1; tv[4].pix[0] = p4(9,10,11,12); tv[4].msk[0] = 4'hF;
    tv[4].ne = 2; tv[4].ew[0] = mk(9'h1FF, 8'hF0, p8(0,0,0,0,9,9,10,10));
    tv[4].ew[1] = mk(9'h000, 8'h0F, p8(11,11,12,12,0,0,0,0));

    #1;
    chk("reset out_valid", 128'(out_valid), 128'(0));
    chk("reset in_ready", 128'(in_ready), 128'(0));
    chk("reset out_addr", 128'(out_addr), 128'(0));
    chk("reset out_mask", 128'(out_mask), 128'(0));
    chk("reset out_pixels", 128'(out_pixels), 128'(0));
    repeat (3) @(negedge clk_draw);
    rst_draw_n = 1'b1;
    #1;
    chk("in_ready before first edge", 128'(in_ready), 128'(0));
    @(posedge clk_draw);
    #1;
    chk("in_ready after first edge", 128'(in_ready), 128'(1));

    for (int i = 0; i < 4; i++) begin
      run_vec(tv[i]);
      drain();
      chk("in_ready after span", 128'(in_ready), 128'(1));
    end

    stall = 1'b1;
    repeat (2) begin @(posedge clk_draw); #1; end
    run_vec(tv[4]);
    repeat (5) begin
      @(negedge clk_draw);
      chk("stall out_valid", 128'(out_valid), 128'(1));
      chk("stall out_addr", 128'(out_addr), 128'(9'h1FF));
      chk("stall out_mask", 128'(out_mask), 128'(8'hF0));
      chk("stall in_ready", 128'(in_ready), 128'(0));
    end
    stall = 1'b0;
    drain();

    stall = 1'b1;
    repeat (2) begin @(posedge clk_draw); #1; end
    send(tv[2].pix[0], tv[2].msk[0], 1'b1, 1'b1, tv[2].x, tv[2].sc);
    @(negedge clk_draw);
    chk("pre-reset out_valid", 128'(out_valid), 128'(1));
    #2;
    rst_draw_n = 1'b0;
    #1;
    chk("async reset out_valid", 128'(out_valid), 128'(0));
    chk("async reset out_mask", 128'(out_mask), 128'(0));
    chk("async reset in_ready", 128'(in_ready), 128'(0));
    exp_q.delete();
    @(negedge clk_draw);
    rst_draw_n = 1'b1;
    stall = 1'b0;
    @(posedge clk_draw);
    #1;
    chk("in_ready after re-reset", 128'(in_ready), 128'(1));
    run_vec(tv[0]);
    drain();

    rand_mode = 1'b1;
    for (int s = 0; s < 150; s++) begin
      x  = 12'($urandom());
      sc = 2'($urandom());
      nb = $urandom_range(1, 4);
      for (int b = 0; b < 4; b++) begin
        rp[b] = 36'({$urandom(), $urandom()});
        rm[b] = ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom());
      end
      model_span(x, sc, nb);
      for (int b = 0; b < nb; b++) send(rp[b], rm[b], b == 0, b == nb - 1, x, sc);
      repeat ($urandom_range(0, 2)) begin @(posedge clk_draw); #1; end
    end
    rand_mode = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
